// File: rtl/br_checkpoint_stack.sv
// Per-branch checkpoint store (map table, free-list head, ROB tail) indexed by one-hot branch bit.
// Optional protocol checking is built when BR_CKPT_CHECK_EN is defined; otherwise err_o is tied 0.
module br_checkpoint_stack #(
   parameter int BR_MASK_W  = 5,
   parameter int ARCH_REG_N = 32,
   parameter int PRF_IDX_W  = 6,
   parameter int FL_PTR_W   = 5,
   parameter int ROB_IDX_W  = 5
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            save_en_i,
   input  logic [BR_MASK_W-1:0]            save_bit_i,
   input  logic [BR_MASK_W-1:0]            save_dep_mask_i,
   input  logic [ARCH_REG_N*PRF_IDX_W-1:0] map_table_i,
   input  logic [FL_PTR_W-1:0]             fl_head_i,
   input  logic [ROB_IDX_W-1:0]            rob_tail_i,
   input  logic [1:0]                      br_state_i,
   input  logic [BR_MASK_W-1:0]            br_bit_i,
   output logic                            rc_valid_o,
   output logic [ARCH_REG_N*PRF_IDX_W-1:0] rc_map_table_o,
   output logic [FL_PTR_W-1:0]             rc_fl_head_o,
   output logic [ROB_IDX_W-1:0]            rc_rob_tail_o,
   output logic [BR_MASK_W-1:0]            slot_valid_o,
   output logic                            err_o
);
   localparam int MAP_W = ARCH_REG_N*PRF_IDX_W;

   logic [BR_MASK_W-1:0]                valid;
   logic [BR_MASK_W-1:0][BR_MASK_W-1:0] dep;
   logic [BR_MASK_W-1:0][MAP_W-1:0]     map_q;
   logic [BR_MASK_W-1:0][FL_PTR_W-1:0]  fl_q;
   logic [BR_MASK_W-1:0][ROB_IDX_W-1:0] rob_q;

   logic                 is_correct, is_wrong;
   logic [BR_MASK_W-1:0] freed, kill, save_wr, valid_nxt;
   logic [MAP_W-1:0]     rd_map;
   logic [FL_PTR_W-1:0]  rd_fl;
   logic [ROB_IDX_W-1:0] rd_rob;

   assign is_correct = (br_state_i == 2'b01);
   assign is_wrong   = (br_state_i == 2'b10);

   always_comb begin
      freed   = is_correct ? br_bit_i : '0;
      // a mispredict squashes dispatch, so its concurrent save is dropped
      save_wr = (save_en_i && !is_wrong) ? save_bit_i : '0;
      kill    = '0;
      rd_map  = '0;
      rd_fl   = '0;
      rd_rob  = '0;
      for (int j = 0; j < BR_MASK_W; j++) begin
         kill[j] = is_wrong && ((|(dep[j] & br_bit_i)) || br_bit_i[j]);
         if (br_bit_i[j]) begin
            rd_map = rd_map | map_q[j];
            rd_fl  = rd_fl  | fl_q[j];
            rd_rob = rd_rob | rob_q[j];
         end
      end
      valid_nxt = (valid & ~freed & ~kill) | save_wr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid          <= '0;
         dep            <= '0;
         rc_valid_o     <= 1'b0;
         rc_map_table_o <= '0;
         rc_fl_head_o   <= '0;
         rc_rob_tail_o  <= '0;
      end else begin
         valid      <= valid_nxt;
         rc_valid_o <= is_wrong;
         for (int j = 0; j < BR_MASK_W; j++)
            dep[j] <= save_wr[j] ? (save_dep_mask_i & ~freed) : (dep[j] & ~freed);
         if (is_wrong) begin
            rc_map_table_o <= rd_map;
            rc_fl_head_o   <= rd_fl;
            rc_rob_tail_o  <= rd_rob;
         end
      end
   end

   // snapshot payload carries no reset
   always_ff @(posedge clk) begin
      for (int j = 0; j < BR_MASK_W; j++) begin
         if (!rst && save_wr[j]) begin
            map_q[j] <= map_table_i;
            fl_q[j]  <= fl_head_i;
            rob_q[j] <= rob_tail_i;
         end
      end
   end

   assign slot_valid_o = valid;

`ifdef BR_CKPT_CHECK_EN
   logic err_q, err_now;
   logic save_1h, br_1h;

   always_comb begin
      save_1h = (save_bit_i != '0) && ((save_bit_i & (save_bit_i - 1'b1)) == '0);
      br_1h   = (br_bit_i != '0) && ((br_bit_i & (br_bit_i - 1'b1)) == '0);
      err_now = 1'b0;
      if (save_en_i && !is_wrong)
         err_now = !save_1h || (|(save_bit_i & valid & ~freed));
      if (is_correct || is_wrong)
         err_now = err_now || !br_1h || !(|(br_bit_i & valid));
   end

   always_ff @(posedge clk) begin
      if (rst)          err_q <= 1'b0;
      else if (err_now) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_br_checkpoint_stack.sv
// Randomized bench for br_checkpoint_stack against a slot-array reference model.
module tb_br_checkpoint_stack;
   localparam int N  = 5;
   localparam int MW = 32*6;

   logic          clk = 0, rst;
   logic          save_en_i;
   logic [N-1:0]  save_bit_i, save_dep_mask_i, br_bit_i;
   logic [MW-1:0] map_table_i;
   logic [4:0]    fl_head_i, rob_tail_i;
   logic [1:0]    br_state_i;
   logic          rc_valid_o, err_o;
   logic [MW-1:0] rc_map_table_o;
   logic [4:0]    rc_fl_head_o, rc_rob_tail_o;
   logic [N-1:0]  slot_valid_o;

   br_checkpoint_stack dut (
      .clk(clk), .rst(rst), .save_en_i(save_en_i), .save_bit_i(save_bit_i),
      .save_dep_mask_i(save_dep_mask_i), .map_table_i(map_table_i), .fl_head_i(fl_head_i),
      .rob_tail_i(rob_tail_i), .br_state_i(br_state_i), .br_bit_i(br_bit_i),
      .rc_valid_o(rc_valid_o), .rc_map_table_o(rc_map_table_o), .rc_fl_head_o(rc_fl_head_o),
      .rc_rob_tail_o(rc_rob_tail_o), .slot_valid_o(slot_valid_o), .err_o(err_o));

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0;

   // reference model: one record per slot
   logic [N-1:0]  m_valid = '0;
   logic [N-1:0]  m_dep [N];
   logic [MW-1:0] m_map [N];
   logic [4:0]    m_fl [N], m_rob [N];
   bit            written [N];
   bit            e_rc_vld = 0, e_rc_known = 0, m_err = 0;
   logic [MW-1:0] e_map;
   logic [4:0]    e_fl, e_rob;

   task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit onehot(input logic [N-1:0] x);
      int c = 0;
      for (int k = 0; k < N; k++) c += int'(x[k]);
      return c == 1;
   endfunction

   function automatic logic [MW-1:0] rmap();
      logic [MW-1:0] r;
      for (int k = 0; k < MW; k += 32) r[k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [MW-1:0] imap();
      logic [MW-1:0] r;
      for (int k = 0; k < 32; k++) r[k*6 +: 6] = 6'(k);
      return r;
   endfunction

   task automatic model_step();
      bit c = (br_state_i == 2'b01), w = (br_state_i == 2'b10);
      logic [N-1:0] nv;
      if (rst) begin
         m_valid = '0; m_err = 0; e_rc_vld = 0;
         for (int j = 0; j < N; j++) m_dep[j] = '0;
         return;
      end
      if (save_en_i && !w)
         if (!onehot(save_bit_i) || (save_bit_i & m_valid & ~(c ? br_bit_i : '0)) != 0) m_err = 1;
      if ((c || w) && (!onehot(br_bit_i) || (br_bit_i & m_valid) == 0)) m_err = 1;
      e_rc_vld = w;
      if (w) begin
         nv = m_valid & ~br_bit_i;
         e_map = '0; e_fl = '0; e_rob = '0; e_rc_known = 1;
         for (int j = 0; j < N; j++) begin
            if ((m_dep[j] & br_bit_i) != 0) nv[j] = 0;
            if (br_bit_i[j]) begin
               e_map = m_map[j]; e_fl = m_fl[j]; e_rob = m_rob[j]; e_rc_known = written[j];
            end
         end
      end else begin
         nv = m_valid;
         if (c) begin
            nv &= ~br_bit_i;
            for (int j = 0; j < N; j++) m_dep[j] &= ~br_bit_i;
         end
         if (save_en_i)
            for (int j = 0; j < N; j++)
               if (save_bit_i[j]) begin
                  nv[j] = 1; m_dep[j] = save_dep_mask_i & ~(c ? br_bit_i : '0);
                  m_map[j] = map_table_i; m_fl[j] = fl_head_i; m_rob[j] = rob_tail_i;
                  written[j] = 1;
               end
      end
      m_valid = nv;
   endtask

   task automatic drive(input logic r, input logic se, input logic [N-1:0] sb, input logic [N-1:0] sd,
                        input logic [1:0] st, input logic [N-1:0] bb, input logic [MW-1:0] mp,
                        input logic [4:0] f, input logic [4:0] rb);
      @(negedge clk);
      rst = r; save_en_i = se; save_bit_i = sb; save_dep_mask_i = sd; br_state_i = st;
      br_bit_i = bb; map_table_i = mp; fl_head_i = f; rob_tail_i = rb;
      @(posedge clk);
      model_step();
      #1;
      chk("slot_valid", MW'(slot_valid_o), MW'(m_valid));
      chk("rc_valid", MW'(rc_valid_o), MW'(e_rc_vld));
      if (e_rc_vld && e_rc_known) begin
         chk("rc_map", rc_map_table_o, e_map);
         chk("rc_fl", MW'(rc_fl_head_o), MW'(e_fl));
         chk("rc_rob", MW'(rc_rob_tail_o), MW'(e_rob));
      end
`ifdef BR_CKPT_CHECK_EN
      chk("err", MW'(err_o), MW'(m_err));
`else
      chk("err", MW'(err_o), '0);
`endif
   endtask

   task automatic idle(); drive(0, 0, 0, 0, 0, 0, rmap(), 5'($urandom), 5'($urandom)); endtask
   task automatic do_rst(); drive(1, 0, 0, 0, 0, 0, rmap(), 0, 0); endtask
   task automatic save(input logic [N-1:0] b, input logic [N-1:0] d, input logic [4:0] f);
      drive(0, 1, b, d, 0, 0, rmap(), f, 5'($urandom));
   endtask

   initial begin
      logic [N-1:0] sb, bb, fr;
      logic [1:0]   st;
      rst = 1; save_en_i = 0; save_bit_i = 0; save_dep_mask_i = 0; br_state_i = 0;
      br_bit_i = 0; map_table_i = 0; fl_head_i = 0; rob_tail_i = 0;
      do_rst(); do_rst();
      chk("reset_rc_map", rc_map_table_o, '0);
      chk("reset_rc_fl", MW'(rc_fl_head_o), '0);

      // identity map snapshot, then mispredict on it
      drive(0, 1, 5'b00001, 0, 0, 0, imap(), 5'd3, 5'd7);
      drive(0, 0, 0, 0, 2'b10, 5'b00001, rmap(), 0, 0);
      chk("t1_map", rc_map_table_o, imap());
      chk("t1_fl", MW'(rc_fl_head_o), MW'(3));
      idle();

      // nested branches: wrong on middle kills the youngest
      do_rst();
      save(5'b00001, 5'b00000, 5'd1); save(5'b00010, 5'b00001, 5'd2); save(5'b00100, 5'b00011, 5'd4);
      drive(0, 0, 0, 0, 2'b10, 5'b00010, rmap(), 0, 0);
      chk("t2_valid", MW'(slot_valid_o), MW'(5'b00001));
      chk("t2_fl", MW'(rc_fl_head_o), MW'(2));

      // correct on oldest, then wrong on freed slot
      do_rst();
      save(5'b00001, 5'b00000, 5'd1); save(5'b00010, 5'b00001, 5'd2); save(5'b00100, 5'b00011, 5'd4);
      drive(0, 0, 0, 0, 2'b01, 5'b00001, rmap(), 0, 0);
      chk("t3_valid", MW'(slot_valid_o), MW'(5'b00110));
      drive(0, 0, 0, 0, 2'b10, 5'b00001, rmap(), 0, 0);

      // correct and re-save same slot
      do_rst();
      save(5'b00001, 5'b00000, 5'd1); save(5'b00010, 5'b00001, 5'd2);
      drive(0, 1, 5'b00001, 5'b00001, 2'b01, 5'b00001, rmap(), 5'd9, 5'd0);
      drive(0, 0, 0, 0, 2'b10, 5'b00001, rmap(), 0, 0);
      chk("t4_fl", MW'(rc_fl_head_o), MW'(9));
      chk("t4_valid", MW'(slot_valid_o), MW'(5'b00010));

      // save squashed by concurrent wrong; back-to-back wrongs
      do_rst();
      save(5'b00001, 0, 5'd5); save(5'b00010, 5'b00001, 5'd6); save(5'b10000, 5'b00000, 5'd8);
      drive(0, 1, 5'b01000, 5'b00011, 2'b10, 5'b00010, rmap(), 0, 0);
      chk("t5_valid", MW'(slot_valid_o), MW'(5'b10001));
      drive(0, 0, 0, 0, 2'b10, 5'b10000, rmap(), 0, 0);
      chk("t5_fl2", MW'(rc_fl_head_o), MW'(8));

      // reset coincident with a wrong suppresses the pulse
      save(5'b00100, 0, 5'd1);
      drive(1, 0, 0, 0, 2'b10, 5'b00100, rmap(), 0, 0);
      idle();

      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9: st = 2'b00;
            10, 11, 12, 13, 14:           st = 2'b01;
            15, 16, 17:                   st = 2'b10;
            default:                      st = 2'b11;
         endcase
         bb = 5'b1 << $urandom_range(0, 4);
         if (m_valid != 0 && $urandom_range(0, 9) != 0)
            for (int k = 0; k < 16 && (bb & m_valid) == 0; k++) bb = 5'b1 << $urandom_range(0, 4);
         if ($urandom_range(0, 29) == 0) bb = '0;
         fr = ~m_valid | ((st == 2'b01) ? bb : '0);
         sb = 5'b1 << $urandom_range(0, 4);
         if ($urandom_range(0, 9) != 0)
            for (int k = 0; k < 16 && (sb & fr) == 0; k++) sb = 5'b1 << $urandom_range(0, 4);
         if ($urandom_range(0, 29) == 0) sb = '0;
         drive($urandom_range(0, 49) == 0, 1'($urandom), sb, m_valid & ~sb, st, bb,
               rmap(), 5'($urandom), 5'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
